// File: rtl/sseg_pkg.sv
// Shared types and register-map constants for the seven-segment write sequencer.
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } sseg_state_e;

    localparam int unsigned ADDR_W           = 4;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned CTRL_OFFSET      = 8;
    localparam int unsigned CTRL_REFRESH_BIT = 0;
    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_DIRTY_LSB = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sseg_rr_pick.sv
// Combinational round-robin selector: first dirty digit strictly after last_i, wrapping.
module sseg_rr_pick
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic [NUM_DIGITS-1:0] dirty_i,
    input  logic [IDX_W-1:0]      last_i,
    output logic                  valid_o,
    output logic [IDX_W-1:0]      idx_o
);

    logic [IDX_W-1:0] cand;

    // k runs to NUM_DIGITS so the last-serviced digit itself is the final candidate.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_DIGITS; k++) begin
            cand = IDX_W'((32'(last_i) + k) % NUM_DIGITS);
            if (!valid_o && dirty_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/sseg_write_sequencer.sv
// Avalon-MM digit register file that replays changed digits to the display driver
// as timed setup / strobe / hold write cycles.
module sseg_write_sequencer
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [2:0]        sseg_addr,
    output logic [7:0]        sseg_data,
    output logic              sseg_wr_n
);

    localparam int unsigned CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);

    sseg_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [7:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dirty_q;
    logic [NUM_DIGITS-1:0] dirty_d;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      addr_q;
    logic [7:0]            data_q;
    logic                  wr_n_q;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;
    logic                  bus_wr;
    logic                  digit_wr;
    logic                  ctrl_wr;
    logic                  take;
    logic                  busy;
    logic [IDX_W-1:0]      addr_idx;
    logic                  unused_ok;

    assign bus_wr    = chipselect & ~write_n;
    assign digit_wr  = bus_wr && (address < ADDR_W'(NUM_DIGITS));
    assign ctrl_wr   = bus_wr && (address == ADDR_W'(CTRL_OFFSET));
    assign addr_idx  = address[IDX_W-1:0];
    assign take      = (state_q == ST_IDLE) && pick_valid;
    assign busy      = (state_q != ST_IDLE) || (|dirty_q);
    assign unused_ok = ^writedata[31:8];

    sseg_rr_pick #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_pick (
        .dirty_i (dirty_q),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Bus sets are applied after the service clear so a same-cycle rewrite stays dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (take) begin
            dirty_d[pick_idx] = 1'b0;
        end
        if (ctrl_wr && writedata[CTRL_REFRESH_BIT]) begin
            dirty_d = '1;
        end
        if (digit_wr) begin
            dirty_d[addr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dirty_q <= '1;
            last_q  <= IDX_W'(NUM_DIGITS - 1);
            addr_q  <= '0;
            data_q  <= '0;
            wr_n_q  <= 1'b1;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            dirty_q <= dirty_d;
            if (digit_wr) begin
                digit_q[addr_idx] <= writedata[7:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        addr_q  <= pick_idx;
                        data_q  <= digit_q[pick_idx];
                        last_q  <= pick_idx;
                        cnt_q   <= CNT_W'(SETUP_CYCLES - 1);
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(PULSE_CYCLES - 1);
                        wr_n_q  <= 1'b0;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                        wr_n_q  <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        if (address < ADDR_W'(NUM_DIGITS)) begin
            readdata[7:0] = digit_q[addr_idx];
        end else if (address == ADDR_W'(CTRL_OFFSET)) begin
            readdata[STATUS_BUSY_BIT]       = busy;
            readdata[STATUS_DIRTY_LSB +: 8] = 8'(dirty_q);
        end
    end

    assign sseg_addr = addr_q;
    assign sseg_data = data_q;
    assign sseg_wr_n = wr_n_q;

endmodule
